stream_src_arbiter: RTL and testbench

- Round-robin arbiter that merges NUM_SRC first-word-fall-through 16-bit FIFO sources into one FWFT read interface.
- Sits between the trigger/TDC data producers (tlu_master plus future record sources) and stream_fifo's FIFO_READ_NEXT_OUT / FIFO_EMPTY_IN / FIFO_DATA port.
- Grants one source at a time for a bounded burst, so no source can starve the others.
- Runs entirely in the BUS_CLK domain.

---
 rtl/stream_src_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_stream_src_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_src_arbiter.sv
// -----------------------------------------------------------------------------
// stream_src_arbiter
//
// Round-robin arbiter that merges NUM_SRC first-word-fall-through (FWFT)
// 16-bit sources into a single FWFT read port for stream_fifo. Each grant is
// held for at most MAX_BURST words, so no source can starve the others.
// Everything runs on BUS_CLK. Reset is synchronous and active-low.
//
// Optional feature (compile-time macro): STREAM_SRC_HEADER_EN
//   When defined, every grant first emits one header word
//   {4'hF, 1'b0, GRANT_ID, 8'h00} before the source's data words.
// -----------------------------------------------------------------------------
module stream_src_arbiter #(
    parameter int NUM_SRC   = 2,   // 2..8 upstream sources
    parameter int MAX_BURST = 64   // 1..255 words per grant
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST_N,
    input  logic [NUM_SRC-1:0]    SRC_EN,
    input  logic [NUM_SRC-1:0]    IN_FIFO_EMPTY,
    input  logic [16*NUM_SRC-1:0] IN_FIFO_DATA,
    output logic [NUM_SRC-1:0]    IN_FIFO_READ,
    input  logic                  OUT_FIFO_READ,
    output logic                  OUT_FIFO_EMPTY,
    output logic [15:0]           OUT_FIFO_DATA,
    output logic [2:0]            GRANT_ID,
    output logic                  BUSY
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BURST  = 2'd1
`ifdef STREAM_SRC_HEADER_EN
        , S_HEADER = 2'd2
`endif
    } state_t;

    state_t      r_state;
    logic [2:0]  r_grant;      // currently (or most recently) granted source
    logic [2:0]  r_last;       // last-served source, origin of the round-robin search
    logic [7:0]  r_cnt;        // words popped from the granted source in this grant
    logic        r_busy;

    logic [NUM_SRC-1:0] w_elig;
    logic               w_any_elig;
    logic [2:0]         w_next_grant;

    logic               w_g_empty;
    logic               w_g_en;
    logic [15:0]        w_g_data;

    logic               w_out_empty;
    logic [15:0]        w_out_data;
    logic               w_accept;     // consumer pop that actually takes a word
    logic               w_src_pop;    // accepted pop that must reach the granted source
    logic               w_burst_last; // the current pop uses up the burst budget

    // A source may be granted only when it is enabled and holds data.
    assign w_elig = SRC_EN & ~IN_FIFO_EMPTY;

    // Round-robin search: first eligible index strictly after r_last, wrapping.
    // NOTE: every signal written in a combinational block gets a default at the
    // top so that no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_any_elig   = 1'b0;
        w_next_grant = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!w_any_elig && w_elig[i] &&
                    (i == (int'(r_last) + k) % NUM_SRC)) begin
                    w_any_elig   = 1'b1;
                    w_next_grant = 3'(i);
                end
            end
        end
    end

    // Select the flags and head word of the granted source.
    always_comb begin
        w_g_empty = 1'b1;
        w_g_en    = 1'b0;
        w_g_data  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (r_grant == 3'(i)) begin
                w_g_empty = IN_FIFO_EMPTY[i];
                w_g_en    = SRC_EN[i];
                w_g_data  = IN_FIFO_DATA[16*i +: 16];
            end
        end
    end

    // Merged output port; forced empty while reset is asserted so that no pop
    // can be accepted in the reset cycle.
    always_comb begin
        w_out_empty = 1'b1;
        w_out_data  = '0;
        if (BUS_RST_N) begin
            case (r_state)
                S_BURST: begin
                    // A source disabled mid-burst reads as empty at once.
                    w_out_empty = w_g_empty | ~w_g_en;
                    w_out_data  = w_g_data;
                end
`ifdef STREAM_SRC_HEADER_EN
                S_HEADER: begin
                    w_out_empty = 1'b0;
                    w_out_data  = {4'hF, 1'b0, r_grant, 8'h00};
                end
`endif
                default: begin
                    w_out_empty = 1'b1;
                    w_out_data  = '0;
                end
            endcase
        end
    end

    assign w_accept     = OUT_FIFO_READ & ~w_out_empty;
    assign w_src_pop    = w_accept & (r_state == S_BURST);
    assign w_burst_last = (r_cnt == 8'(MAX_BURST - 1));

    // Route an accepted data pop to the granted source only.
    always_comb begin
        IN_FIFO_READ = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (w_src_pop && (r_grant == 3'(i))) begin
                IN_FIFO_READ[i] = 1'b1;
            end
        end
    end

    assign OUT_FIFO_EMPTY = w_out_empty;
    assign OUT_FIFO_DATA  = w_out_data;
    assign GRANT_ID       = r_grant;
    assign BUSY           = r_busy;

    // Grant FSM: picks a source in IDLE, streams it in BURST, releases on
    // burst budget exhaustion or when the source runs dry / is disabled.
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples the pre-edge values of its inputs.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_last  <= 3'(NUM_SRC - 1);
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_elig) begin
                        r_grant <= w_next_grant;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
`ifdef STREAM_SRC_HEADER_EN
                        r_state <= S_HEADER;
`else
                        r_state <= S_BURST;
`endif
                    end
                end

`ifdef STREAM_SRC_HEADER_EN
                S_HEADER: begin
                    // The header pop neither touches a source nor counts
                    // toward the burst budget.
                    if (w_accept) begin
                        r_state <= S_BURST;
                    end
                end
`endif

                S_BURST: begin
                    if (w_src_pop) begin
                        if (w_burst_last) begin
                            r_state <= S_IDLE;
                            r_last  <= r_grant;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end else if (w_out_empty) begin
                        r_state <= S_IDLE;
                        r_last  <= r_grant;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_src_arbiter.sv
// -----------------------------------------------------------------------------
// tb_stream_src_arbiter
//
// Two FWFT sources modelled as queues feed the arbiter; the consumer side
// compares every accepted word against a scoreboard queue filled when the
// sources are loaded. Build with STREAM_SRC_HEADER_EN to exercise headers.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_stream_src_arbiter;

    localparam int NUM_SRC   = 2;
    localparam int MAX_BURST = 4;

`ifdef STREAM_SRC_HEADER_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NUM_SRC-1:0]    src_en;
    logic [NUM_SRC-1:0]    in_empty;
    logic [16*NUM_SRC-1:0] in_data;
    logic [NUM_SRC-1:0]    in_rd;
    logic                  out_rd;
    logic                  out_empty;
    logic [15:0]           out_data;
    logic [2:0]            grant_id;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] src0_q[$];
    logic [15:0] src1_q[$];
    logic [15:0] exp_q[$];
    int          gaps_q[$];
    int          gap_run = 0;
    int          pop_cnt[NUM_SRC];

    stream_src_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .MAX_BURST (MAX_BURST)
    ) u_dut (
        .BUS_CLK        (clk),
        .BUS_RST_N      (rst_n),
        .SRC_EN         (src_en),
        .IN_FIFO_EMPTY  (in_empty),
        .IN_FIFO_DATA   (in_data),
        .IN_FIFO_READ   (in_rd),
        .OUT_FIFO_READ  (out_rd),
        .OUT_FIFO_EMPTY (out_empty),
        .OUT_FIFO_DATA  (out_data),
        .GRANT_ID       (grant_id),
        .BUSY           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    function automatic logic [15:0] hdr_word(input logic [2:0] g);
        return {4'hF, 1'b0, g, 8'h00};
    endfunction

    task automatic exp_header(input logic [2:0] g);
        if (HDR_EN) exp_q.push_back(hdr_word(g));
    endtask

    task automatic clear_pop_cnt();
        foreach (pop_cnt[i]) pop_cnt[i] = 0;
    endtask

    task automatic drive_srcs();
        in_empty[0]    = (src0_q.size() == 0);
        in_empty[1]    = (src1_q.size() == 0);
        in_data[15:0]  = in_empty[0] ? 16'h0000 : src0_q[0];
        in_data[31:16] = in_empty[1] ? 16'h0000 : src1_q[0];
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        gap_run = 0;
    endtask

    // One clock: sample at negedge, score accepted word, then apply source pops
    // just after the rising edge.
    task automatic tick();
        logic [NUM_SRC-1:0] rd;
        logic               acc;
        @(negedge clk);
        rd  = in_rd;
        acc = out_rd && !out_empty;
        if (out_empty) gap_run++;
        if (acc) begin
            gaps_q.push_back(gap_run);
            gap_run = 0;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: got word %h, expected none", out_data);
            end else begin
                if (out_data !== exp_q[0]) begin
                    n_fail++;
                    $display("FAIL scoreboard: got %h, expected %h", out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        if (rd != '0) begin
            n_tests++;
            if (!acc || $countones(rd) != 1 ||
                (rd[0] && src0_q.size() == 0) || (rd[1] && src1_q.size() == 0)) begin
                n_fail++;
                $display("FAIL in_fifo_read: got %b with accept=%b, src sizes %0d/%0d",
                         rd, acc, src0_q.size(), src1_q.size());
            end
        end
        @(posedge clk);
        #1;
        if (rd[0] && src0_q.size() > 0) begin void'(src0_q.pop_front()); pop_cnt[0]++; end
        if (rd[1] && src1_q.size() > 0) begin void'(src1_q.pop_front()); pop_cnt[1]++; end
        drive_srcs();
    endtask

    task automatic drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s drain: %0d words outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_tests += 5;
        if (out_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b, required 1", out_empty); end
        if (in_rd !== '0) begin n_fail++; $display("FAIL reset_in_rd: got %b, required 0", in_rd); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (grant_id !== 3'd0) begin n_fail++; $display("FAIL reset_grant: got %0d, required 0", grant_id); end
        if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_data: got %h, required 0000", out_data); end
    endtask

    task automatic test_single_source();
        clear_pop_cnt();
        exp_header(3'd0);
        for (int k = 1; k <= 3; k++) begin
            src0_q.push_back(16'(k));
            exp_q.push_back(16'(k));
        end
        drive_srcs();
        out_rd = 1'b1;
        tick();
        n_tests++;
        if (grant_id !== 3'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_grant: got grant %0d busy %b, required 0 / 1", grant_id, busy);
        end
        drain("single_source", 20);
        repeat (2) tick();
        n_tests += 4;
        if (pop_cnt[0] != 3) begin n_fail++; $display("FAIL single_pops: got %0d, required 3", pop_cnt[0]); end
        if (out_empty !== 1'b1) begin n_fail++; $display("FAIL single_empty: got %b, required 1", out_empty); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b, required 0", busy); end
        if (grant_id !== 3'd0) begin n_fail++; $display("FAIL single_grant_hold: got %0d, required 0", grant_id); end
        out_rd = 1'b0;
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_pop_cnt();
        gaps_q.delete();
        for (int k = 0; k < 10; k++) begin
            src0_q.push_back(16'h0100 + 16'(k));
            src1_q.push_back(16'h0200 + 16'(k));
        end
        for (int b = 0; b < 3; b++) begin
            for (int s = 0; s < 2; s++) begin
                exp_header(3'(s));
                for (int k = 4 * b; k < 4 * b + 4 && k < 10; k++)
                    exp_q.push_back((s == 0 ? 16'h0100 : 16'h0200) + 16'(k));
            end
        end
        drive_srcs();
        out_rd = 1'b1;
        drain("round_robin", 200);
        repeat (2) tick();
        n_tests += 2;
        if (pop_cnt[0] != 10) begin n_fail++; $display("FAIL rr_pops0: got %0d, required 10", pop_cnt[0]); end
        if (pop_cnt[1] != 10) begin n_fail++; $display("FAIL rr_pops1: got %0d, required 10", pop_cnt[1]); end
`ifndef STREAM_SRC_HEADER_EN
        n_tests++;
        if (gaps_q.size() < 20) begin
            n_fail++;
            $display("FAIL rr_gap_count: got %0d words, required 20", gaps_q.size());
        end else begin
            for (int idx = 1; idx <= 17; idx++) begin
                n_tests++;
                if (gaps_q[idx] != ((idx % 4 == 0) ? 1 : 0)) begin
                    n_fail++;
                    $display("FAIL rr_gap[%0d]: got %0d empty cycles, required %0d",
                             idx, gaps_q[idx], (idx % 4 == 0) ? 1 : 0);
                end
            end
        end
`endif
        out_rd = 1'b0;
    endtask

    task automatic test_src_en_mask();
        clear_pop_cnt();
        src_en = 2'b10;
        exp_header(3'd1);
        for (int k = 0; k < 3; k++) begin
            src0_q.push_back(16'h0A00 + 16'(k));
            src1_q.push_back(16'h0B00 + 16'(k));
            exp_q.push_back(16'h0B00 + 16'(k));
        end
        drive_srcs();
        out_rd = 1'b1;
        drain("src_en_mask", 40);
        repeat (4) tick();
        n_tests += 3;
        if (pop_cnt[0] != 0) begin n_fail++; $display("FAIL mask_pops0: got %0d, required 0", pop_cnt[0]); end
        if (src0_q.size() != 3) begin n_fail++; $display("FAIL mask_src0_left: got %0d, required 3", src0_q.size()); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mask_busy: got %b, required 0", busy); end
        src_en = 2'b11;
        exp_header(3'd0);
        for (int k = 0; k < 3; k++) exp_q.push_back(16'h0A00 + 16'(k));
        drain("src_en_unmask", 40);
        repeat (2) tick();
        n_tests++;
        if (pop_cnt[0] != 3) begin n_fail++; $display("FAIL unmask_pops0: got %0d, required 3", pop_cnt[0]); end
        out_rd = 1'b0;
    endtask

    task automatic test_disable_mid_burst();
        int n;
        clear_pop_cnt();
        src_en = 2'b11;
        for (int k = 0; k < 6; k++) src0_q.push_back(16'h0C00 + 16'(k));
        exp_header(3'd0);
        exp_q.push_back(16'h0C00);
        exp_q.push_back(16'h0C01);
        drive_srcs();
        out_rd = 1'b1;
        n = 0;
        while (pop_cnt[0] < 2 && n < 30) begin tick(); n++; end
        n_tests++;
        if (pop_cnt[0] != 2) begin n_fail++; $display("FAIL disable_setup: got %0d pops, required 2", pop_cnt[0]); end
        src_en = 2'b10;
        @(negedge clk);
        n_tests += 2;
        if (out_empty !== 1'b1) begin n_fail++; $display("FAIL disable_empty: got %b, required 1", out_empty); end
        if (in_rd !== '0) begin n_fail++; $display("FAIL disable_in_rd: got %b, required 0", in_rd); end
        @(posedge clk);
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL disable_release: busy got %b, required 0", busy); end
        repeat (3) tick();
        n_tests++;
        if (pop_cnt[0] != 2) begin n_fail++; $display("FAIL disable_hold: got %0d pops, required 2", pop_cnt[0]); end
        src_en = 2'b11;
        exp_header(3'd0);
        for (int k = 2; k < 6; k++) exp_q.push_back(16'h0C00 + 16'(k));
        drain("disable_resume", 40);
        repeat (2) tick();
        n_tests += 2;
        if (pop_cnt[0] != 6) begin n_fail++; $display("FAIL resume_pops: got %0d, required 6", pop_cnt[0]); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL resume_busy: got %b, required 0", busy); end
        out_rd = 1'b0;
    endtask

    task automatic test_idle_read();
        out_rd = 1'b0;
        repeat (2) tick();
        out_rd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests += 3;
            if (in_rd !== '0) begin n_fail++; $display("FAIL idle_in_rd[%0d]: got %b, required 0", c, in_rd); end
            if (out_empty !== 1'b1) begin n_fail++; $display("FAIL idle_empty[%0d]: got %b, required 1", c, out_empty); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy[%0d]: got %b, required 0", c, busy); end
            @(posedge clk);
            #1;
        end
        out_rd = 1'b0;
        n_tests++;
        if (grant_id !== 3'd0) begin n_fail++; $display("FAIL idle_grant_hold: got %0d, required 0", grant_id); end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        clear_pop_cnt();
        for (int k = 0; k < 5; k++) src0_q.push_back(16'h0D00 + 16'(k));
        exp_header(3'd0);
        exp_q.push_back(16'h0D00);
        drive_srcs();
        out_rd = 1'b1;
        n = 0;
        while (pop_cnt[0] < 1 && n < 20) begin tick(); n++; end
        n_tests++;
        if (pop_cnt[0] != 1) begin n_fail++; $display("FAIL rstmid_setup: got %0d pops, required 1", pop_cnt[0]); end
        src1_q.push_back(16'h0E00);
        src1_q.push_back(16'h0E01);
        drive_srcs();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_rd !== '0) begin n_fail++; $display("FAIL rstmid_in_rd: got %b, required 0", in_rd); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_tests += 3;
        if (out_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b, required 1", out_empty); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
        if (grant_id !== 3'd0) begin n_fail++; $display("FAIL rstmid_grant: got %0d, required 0", grant_id); end
        exp_header(3'd0);
        for (int k = 1; k < 5; k++) exp_q.push_back(16'h0D00 + 16'(k));
        exp_header(3'd1);
        exp_q.push_back(16'h0E00);
        exp_q.push_back(16'h0E01);
        drain("reset_mid_burst", 60);
        repeat (2) tick();
        n_tests += 2;
        if (pop_cnt[0] != 5) begin n_fail++; $display("FAIL rstmid_pops0: got %0d, required 5", pop_cnt[0]); end
        if (pop_cnt[1] != 2) begin n_fail++; $display("FAIL rstmid_pops1: got %0d, required 2", pop_cnt[1]); end
        out_rd = 1'b0;
    endtask

`ifdef STREAM_SRC_HEADER_EN
    task automatic test_header();
        do_reset();
        clear_pop_cnt();
        src1_q.push_back(16'h1234);
        src1_q.push_back(16'h5678);
        exp_q.push_back(16'hF100);
        exp_q.push_back(16'h1234);
        exp_q.push_back(16'h5678);
        drive_srcs();
        out_rd = 1'b1;
        drain("header", 30);
        repeat (2) tick();
        n_tests += 2;
        if (pop_cnt[1] != 2) begin n_fail++; $display("FAIL header_pops1: got %0d, required 2", pop_cnt[1]); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL header_busy: got %b, required 0", busy); end
        out_rd = 1'b0;
    endtask
`endif

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    initial begin
        rst_n    = 1'b0;
        src_en   = '1;
        out_rd   = 1'b0;
        in_empty = '1;
        in_data  = '0;
        clear_pop_cnt();
        drive_srcs();
        test_reset();
        test_single_source();
        test_round_robin();
        test_src_en_mask();
        test_disable_mid_burst();
        test_idle_read();
        test_reset_mid_burst();
`ifdef STREAM_SRC_HEADER_EN
        test_header();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
